fifo_out_stage: RTL and testbench

- Downstream read stage for the team's synchronous FIFO.
- Drains the FIFO's pop/empty interface into a registered valid/ready stream for consumers.
- Holds a 2-entry output buffer, so the FIFO pop decision depends only on local registered state. There is no combinational path from the consumer's m_ready_i to fifo_pop_o.
- Sustains 1 item/cycle when the consumer holds ready.

---
 rtl/fifo_pkg.sv | 11 +
 rtl/fifo_out_stage.sv | 72 +++++++
 tb/tb_fifo_out_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the synchronous FIFO and its downstream read stage.
package fifo_pkg;
    localparam int OUT_DEPTH = 2;

    // Encoded so the state value is directly the buffer occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } out_state_t;
endpackage

// File: rtl/fifo_out_stage.sv
// Read stage for the synchronous FIFO: a 2-entry skid buffer turns pop/empty into a
// registered valid/ready stream, so the pop decision never depends on m_ready_i.
module fifo_out_stage #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic              fifo_pop_o,
    input  logic              flush_i,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    input  logic              m_ready_i,
    output logic [1:0]        occ_o
);
    import fifo_pkg::*;

    // Handshake: an item transfers on a rising edge where m_valid_o && m_ready_i;
    // once valid is raised, m_data_o holds until that transfer, and valid never drops without one
    // except on flush or reset.
    out_state_t        state;
    logic [DATA_W-1:0] slot [OUT_DEPTH];
    logic              wr_idx;
    logic              rd_idx;
    logic              pop;
    logic              drain;

    // Pop uses only registered state and FIFO/flush inputs; reset_n gates it while reset is held.
    assign pop        = reset_n && !fifo_empty_i && (state != TWO) && !flush_i;
    assign drain      = m_valid_o && m_ready_i;
    assign fifo_pop_o = pop;
    assign m_valid_o  = (state != EMPTY);
    assign m_data_o   = slot[rd_idx];
    assign occ_o      = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= EMPTY;
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                slot[i] <= '0;
            end
        end else if (flush_i) begin
            // A drain in this cycle still counts as consumed; its slot is simply abandoned.
            state  <= EMPTY;
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
        end else begin
            if (pop) begin
                slot[wr_idx] <= fifo_data_i;
                wr_idx       <= ~wr_idx;
            end
            if (drain) begin
                rd_idx <= ~rd_idx;
            end
            unique case (state)
                EMPTY: if (pop) state <= ONE;
                ONE: begin
                    if (pop && !drain) begin
                        state <= TWO;
                    end else if (!pop && drain) begin
                        state <= EMPTY;
                    end
                end
                TWO: if (drain) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_out_stage.sv
// Bench for fifo_out_stage: directed scenarios then random traffic, checked against a
// queue model of the source FIFO and the 2-entry output buffer.
module tb_fifo_out_stage;
    localparam int DATA_W = 8;

    logic              clk;
    logic              reset_n;
    logic              fifo_empty_i;
    logic [DATA_W-1:0] fifo_data_i;
    logic              fifo_pop_o;
    logic              flush_i;
    logic              m_valid_o;
    logic [DATA_W-1:0] m_data_o;
    logic              m_ready_i;
    logic [1:0]        occ_o;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] src_q[$];
    logic [DATA_W-1:0] exp_q[$];

    fifo_out_stage #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_pop_o   (fifo_pop_o),
        .flush_i      (flush_i),
        .m_valid_o    (m_valid_o),
        .m_data_o     (m_data_o),
        .m_ready_i    (m_ready_i),
        .occ_o        (occ_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive from negedge, check before posedge, advance the model at posedge.
    task automatic cycle(input logic gate_empty, input logic ready, input logic flush);
        logic exp_pop;
        logic do_drain;
        fifo_empty_i = (src_q.size() == 0) || gate_empty;
        fifo_data_i  = fifo_empty_i ? DATA_W'($urandom) : src_q[0];
        m_ready_i    = ready;
        flush_i      = flush;
        #1;
        exp_pop = !fifo_empty_i && (exp_q.size() < 2) && !flush;
        chk("pop", 32'(fifo_pop_o), 32'(exp_pop));
        if (fifo_empty_i) chk("pop_while_empty", 32'(fifo_pop_o), 32'd0);
        chk("valid", 32'(m_valid_o), 32'(exp_q.size() != 0));
        chk("occ", 32'(occ_o), 32'(exp_q.size()));
        if (exp_q.size() != 0) chk("data", 32'(m_data_o), 32'(exp_q[0]));
        @(posedge clk);
        do_drain = (exp_q.size() != 0) && ready;
        if (do_drain) void'(exp_q.pop_front());
        if (flush) exp_q.delete();
        else if (exp_pop) exp_q.push_back(src_q.pop_front());
        @(negedge clk);
    endtask

    initial begin
        reset_n      = 1'b0;
        fifo_empty_i = 1'b0;
        fifo_data_i  = 8'h77;
        flush_i      = 1'b0;
        m_ready_i    = 1'b1;

        // Reset state, with the FIFO claiming data: pop must stay low.
        @(negedge clk);
        chk("rst_pop", 32'(fifo_pop_o), 32'd0);
        chk("rst_valid", 32'(m_valid_o), 32'd0);
        chk("rst_data", 32'(m_data_o), 32'd0);
        chk("rst_occ", 32'(occ_o), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Streaming with ready held: A,B,C at one per cycle, occupancy stays 1.
        src_q = '{8'h0A, 8'h0B, 8'h0C};
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0);

        // Backpressure: four items, ready low -> only two popped, head stable.
        src_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
        chk("bp_remaining", 32'(src_q.size()), 32'd2);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0);

        // ONE with FIFO empty: drains to EMPTY, no pops.
        src_q = '{8'h21};
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);

        // Flush from TWO, then refill with fresh indices.
        src_q = '{8'h31, 8'h32};
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
        src_q.push_back(8'h33);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        src_q = '{8'h05};
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream while full.
        src_q = '{8'h41, 8'h42, 8'h43, 8'h44};
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
        fifo_empty_i = 1'b0;
        fifo_data_i  = src_q[0];
        m_ready_i    = 1'b0;
        flush_i      = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(m_valid_o), 32'd0);
        chk("arst_data", 32'(m_data_o), 32'd0);
        chk("arst_occ", 32'(occ_o), 32'd0);
        chk("arst_pop", 32'(fifo_pop_o), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0);

        // Random traffic: bursty supply, random gating, ready and rare flushes.
        for (int i = 0; i < 10000; i++) begin
            if (src_q.size() < 8 && $urandom_range(0, 1) == 1) src_q.push_back(DATA_W'($urandom));
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
